// File: rtl/circ_fifo.sv
// circ_fifo: parametrised circular-buffer FIFO, first-word-fall-through.
// Explicitly wrapping read/write pointers allow any DEPTH >= 2. Occupancy is
// held in its own register, and every status flag is decoded from it.
// Optional feature macro: CIRC_FIFO_ERR_FLAGS_EN enables the sticky
// overflow/underflow flags and their clear input. When it is not defined,
// o_ovf and o_udf are tied to 0 and i_clr_err is ignored.
module circ_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_dat_in,
    input  logic                       i_pop,
    output logic [DATA_W-1:0]          o_dat_out,
    output logic [$clog2(DEPTH+1)-1:0] o_ocp,
    output logic                       o_is_full,
    output logic                       o_is_empty,
    output logic                       o_almost_full,
    output logic                       o_almost_empty,
    output logic                       o_ovf,
    output logic                       o_udf,
    input  logic                       i_clr_err
);

    localparam int OCP_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [OCP_W-1:0] OCP_FULL = OCP_W'(DEPTH);
    localparam logic [OCP_W-1:0] OCP_AF   = OCP_W'(AF_LVL);
    localparam logic [OCP_W-1:0] OCP_AE   = OCP_W'(AE_LVL);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [OCP_W-1:0]  r_ocp;

    logic              w_full;
    logic              w_empty;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [PTR_W-1:0]  w_wr_ptr_nxt;
    logic [PTR_W-1:0]  w_rd_ptr_nxt;

    // Status decode from the occupancy register only.
    assign w_full  = (r_ocp == OCP_FULL);
    assign w_empty = (r_ocp == '0);

    // A pop on a full FIFO frees a slot in the same cycle, so the push is
    // accepted too. There is no empty bypass: a pop on an empty FIFO is always
    // rejected. Flush masks both requests.
    assign w_wr_acc = ~i_flush & i_push & (~w_full | i_pop);
    assign w_rd_acc = ~i_flush & i_pop & ~w_empty;

    // Explicit wrap at DEPTH-1, so the pointers also work for non-power-of-two depths.
    assign w_wr_ptr_nxt = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_nxt = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;

    // Storage write; contents are not reset because stale data is never visible.
    always_ff @(posedge i_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= i_dat_in;
        end
    end

    // Pointer and occupancy update. Flush takes priority over push and pop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ocp    <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ocp    <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_ocp <= r_ocp + 1'b1;
                2'b01:   r_ocp <= r_ocp - 1'b1;
                default: r_ocp <= r_ocp;
            endcase
        end
    end

`ifdef CIRC_FIFO_ERR_FLAGS_EN
    logic r_ovf;
    logic r_udf;
    logic w_set_ovf;
    logic w_set_udf;

    assign w_set_ovf = ~i_flush & i_push & w_full & ~i_pop;
    assign w_set_udf = ~i_flush & i_pop & w_empty;

    // Sticky error flags. A set in the same cycle wins over a clear, and flush leaves them alone.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (w_set_ovf) begin
                r_ovf <= 1'b1;
            end else if (i_clr_err) begin
                r_ovf <= 1'b0;
            end
            if (w_set_udf) begin
                r_udf <= 1'b1;
            end else if (i_clr_err) begin
                r_udf <= 1'b0;
            end
        end
    end

    assign o_ovf = r_ovf;
    assign o_udf = r_udf;
`else
    logic w_unused_clr;
    assign w_unused_clr = i_clr_err;
    assign o_ovf = 1'b0;
    assign o_udf = 1'b0;
`endif

    assign o_dat_out      = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_ocp          = r_ocp;
    assign o_is_full      = w_full;
    assign o_is_empty     = w_empty;
    assign o_almost_full  = (r_ocp >= OCP_AF);
    assign o_almost_empty = (r_ocp <= OCP_AE);

endmodule

// File: tb/tb_circ_fifo.sv
// Testbench for circ_fifo. Two instances are exercised: a 5-deep, 8-bit FIFO
// (a_*) and a 16-deep, 32-bit FIFO (b_*). Each instance is compared against
// a queue-based reference model.
module tb_circ_fifo;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // 5-deep, 8-bit instance
    logic       a_flush = 0, a_push = 0, a_pop = 0, a_clr = 0;
    logic [7:0] a_din = '0, a_dout;
    logic [2:0] a_ocp;
    logic       a_full, a_empty, a_af, a_ae, a_ovf, a_udf;

    // 16-deep, 32-bit instance
    logic        b_flush = 0, b_push = 0, b_pop = 0, b_clr = 0;
    logic [31:0] b_din = '0, b_dout;
    logic [4:0]  b_ocp;
    logic        b_full, b_empty, b_af, b_ae, b_ovf, b_udf;

    circ_fifo #(.DATA_W(8), .DEPTH(5), .AF_LVL(3), .AE_LVL(1)) u_a (
        .i_clk(clk), .i_rst(rst), .i_flush(a_flush), .i_push(a_push),
        .i_dat_in(a_din), .i_pop(a_pop), .o_dat_out(a_dout), .o_ocp(a_ocp),
        .o_is_full(a_full), .o_is_empty(a_empty), .o_almost_full(a_af),
        .o_almost_empty(a_ae), .o_ovf(a_ovf), .o_udf(a_udf), .i_clr_err(a_clr)
    );

    circ_fifo #(.DATA_W(32), .DEPTH(16)) u_b (
        .i_clk(clk), .i_rst(rst), .i_flush(b_flush), .i_push(b_push),
        .i_dat_in(b_din), .i_pop(b_pop), .o_dat_out(b_dout), .o_ocp(b_ocp),
        .o_is_full(b_full), .o_is_empty(b_empty), .o_almost_full(b_af),
        .o_almost_empty(b_ae), .o_ovf(b_ovf), .o_udf(b_udf), .i_clr_err(b_clr)
    );

`ifdef CIRC_FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference state: queue contents plus sticky error flags.
    logic [7:0]  qa[$];
    logic [31:0] qb[$];
    bit ea_o = 0, ea_u = 0, eb_o = 0, eb_u = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag);
        int n = qa.size();
        chk({tag, " a.dout"},  32'(a_dout),  (n == 0) ? 32'd0 : 32'(qa[0]));
        chk({tag, " a.ocp"},   32'(a_ocp),   32'(n));
        chk({tag, " a.full"},  32'(a_full),  32'(n == 5));
        chk({tag, " a.empty"}, 32'(a_empty), 32'(n == 0));
        chk({tag, " a.af"},    32'(a_af),    32'(n >= 3));
        chk({tag, " a.ae"},    32'(a_ae),    32'(n <= 1));
        chk({tag, " a.ovf"},   32'(a_ovf),   32'(ea_o));
        chk({tag, " a.udf"},   32'(a_udf),   32'(ea_u));
    endtask

    task automatic check_b(input string tag);
        int n = qb.size();
        chk({tag, " b.dout"},  b_dout,       (n == 0) ? 32'd0 : qb[0]);
        chk({tag, " b.ocp"},   32'(b_ocp),   32'(n));
        chk({tag, " b.full"},  32'(b_full),  32'(n == 16));
        chk({tag, " b.empty"}, 32'(b_empty), 32'(n == 0));
        chk({tag, " b.af"},    32'(b_af),    32'(n >= 14));
        chk({tag, " b.ae"},    32'(b_ae),    32'(n <= 2));
        chk({tag, " b.ovf"},   32'(b_ovf),   32'(eb_o));
        chk({tag, " b.udf"},   32'(b_udf),   32'(eb_u));
    endtask

    // One clock on instance A, with model update and checks 1 time unit after the edge.
    task automatic step_a(input string tag, input bit push, input bit pop,
                          input logic [7:0] din, input bit flush, input bit clr);
        bit full, empty;
        a_push = push; a_pop = pop; a_din = din; a_flush = flush; a_clr = clr;
        @(posedge clk);
        full  = (qa.size() == 5);
        empty = (qa.size() == 0);
        if (flush) begin
            qa.delete();
        end else begin
            if (pop && !empty) void'(qa.pop_front());
            if (push && (!full || pop)) qa.push_back(din);
        end
        if (ERR_EN) begin
            if (!flush && push && full && !pop) ea_o = 1;
            else if (clr) ea_o = 0;
            if (!flush && pop && empty) ea_u = 1;
            else if (clr) ea_u = 0;
        end
        #1;
        check_a(tag);
        a_push = 0; a_pop = 0; a_flush = 0; a_clr = 0;
    endtask

    task automatic step_b(input string tag, input bit push, input bit pop,
                          input logic [31:0] din, input bit flush, input bit clr);
        bit full, empty;
        b_push = push; b_pop = pop; b_din = din; b_flush = flush; b_clr = clr;
        @(posedge clk);
        full  = (qb.size() == 16);
        empty = (qb.size() == 0);
        if (flush) begin
            qb.delete();
        end else begin
            if (pop && !empty) void'(qb.pop_front());
            if (push && (!full || pop)) qb.push_back(din);
        end
        if (ERR_EN) begin
            if (!flush && push && full && !pop) eb_o = 1;
            else if (clr) eb_o = 0;
            if (!flush && pop && empty) eb_u = 1;
            else if (clr) eb_u = 0;
        end
        #1;
        check_b(tag);
        b_push = 0; b_pop = 0; b_flush = 0; b_clr = 0;
    endtask

    task automatic model_reset();
        qa.delete(); qb.delete();
        ea_o = 0; ea_u = 0; eb_o = 0; eb_u = 0;
    endtask

    initial begin
        // Reset applied asynchronously before the first clock edge.
        #1 rst = 1'b1;
        #2;
        model_reset();
        check_a("reset");
        check_b("reset");
        @(posedge clk);
        #3 rst = 1'b0;
        step_a("idle", 0, 0, 8'h00, 0, 0);
        step_b("idle", 0, 0, 32'h0, 0, 0);

        // Depth 5: fill, drop on overflow, drain in order, then underflow.
        for (int i = 0; i < 5; i++) step_a("fill5", 1, 0, 8'(8'h11 + i), 0, 0);
        step_a("ovf5", 1, 0, 8'h99, 0, 0);
        chk("ovf5 full", 32'(a_full), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("drain5 head", 32'(a_dout), 32'(8'h11 + i));
            step_a("drain5", 0, 1, 8'h00, 0, 0);
        end
        step_a("udf5", 0, 1, 8'h00, 0, 0);
        step_a("clr5", 0, 0, 8'h00, 0, 1);

        // Depth 5: pointer wrap past the last slot.
        for (int i = 0; i < 3; i++) step_a("wrap push3", 1, 0, 8'(8'h30 + i), 0, 0);
        for (int i = 0; i < 3; i++) step_a("wrap pop3", 0, 1, 8'h00, 0, 0);
        for (int i = 0; i < 5; i++) step_a("wrap push5", 1, 0, 8'(8'hA0 + i), 0, 0);
        for (int i = 0; i < 5; i++) begin
            chk("wrap head", 32'(a_dout), 32'(8'hA0 + i));
            step_a("wrap pop5", 0, 1, 8'h00, 0, 0);
        end

        // Depth 16: push and pop together on a full FIFO.
        for (int i = 0; i < 16; i++) step_b("fill16", 1, 0, $urandom, 0, 0);
        step_b("full push+pop", 1, 1, 32'hAB, 0, 0);
        chk("full push+pop ocp", 32'(b_ocp), 32'd16);
        for (int i = 0; i < 15; i++) step_b("pop15", 0, 1, 32'h0, 0, 0);
        chk("last is AB", b_dout, 32'hAB);
        step_b("pop AB", 0, 1, 32'h0, 0, 0);

        // Depth 16: push and pop together on an empty FIFO, then clear behaviour.
        step_b("empty push+pop", 1, 1, 32'h42, 0, 0);
        chk("no bypass dout", b_dout, 32'h42);
        step_b("clr udf", 0, 0, 32'h0, 0, 1);
        step_b("pop1", 0, 1, 32'h0, 0, 0);
        step_b("set beats clr", 0, 1, 32'h0, 0, 1);
        step_b("clr again", 0, 0, 32'h0, 0, 1);

        // Depth 16: flush with push and pop in the same cycle.
        for (int i = 0; i < 7; i++) step_b("push7", 1, 0, $urandom, 0, 0);
        step_b("flush", 1, 1, 32'hDEAD, 1, 0);
        step_b("flush on empty", 0, 1, 32'h0, 1, 0);

        // Randomised traffic on both instances.
        for (int i = 0; i < 300; i++) begin
            step_a("rand a", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   8'($urandom), ($urandom_range(0, 49) == 0), ($urandom_range(0, 15) == 0));
            step_b("rand b", ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0),
                   $urandom, ($urandom_range(0, 79) == 0), ($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 200; i++)
            step_b("rand b drain", ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) != 0),
                   $urandom, 1'b0, ($urandom_range(0, 15) == 0));

        // Reset asserted in the middle of a push burst, checked before the next edge.
        for (int i = 0; i < 4; i++) step_b("burst", 1, 0, $urandom, 0, 0);
        for (int i = 0; i < 3; i++) step_a("burst", 1, 0, 8'($urandom), 0, 0);
        b_push = 1; b_din = 32'h5555;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_a("mid reset");
        check_b("mid reset");
        @(negedge clk);
        rst = 1'b0;
        b_push = 0;
        step_b("post reset", 1, 0, 32'h77, 0, 0);
        step_a("post reset", 0, 1, 8'h00, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
